// File: rtl/ysyx_24110006_lsu_if.sv
// ----------------------------------------------------------------------------
// ysyx_24110006_lsu_if : AXI4-Lite-style data bus between the LSU and memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ysyx_24110006_lsu_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_24110006_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_24110006_lsu : memory-access stage, load/store over the data bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_24110006_lsu #(
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [3:0]  i_mem_wmask,
  input  logic [2:0]  i_mem_read_t,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [31:0] i_result,
  input  logic [4:0]  i_reg_rd,
  input  logic        i_reg_wen,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_reg_rd,
  output logic        o_reg_wen,
  output logic [31:0] o_pc,
  output logic        o_err,
  ysyx_24110006_lsu_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AWW  = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  logic [2:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      addr_q,    addr_d;
  logic [2:0]       read_t_q,  read_t_d;
  logic [31:0]      wdata_q,   wdata_d;
  logic [3:0]       wstrb_q,   wstrb_d;
  logic             awvalid_q, awvalid_d;
  logic             wvalid_q,  wvalid_d;
  logic [31:0]      result_q,  result_d;
  logic             err_q,     err_d;
  logic [4:0]       rd_q,      rd_d;
  logic             reg_wen_q, reg_wen_d;
  logic [31:0]      pc_q,      pc_d;

  logic        misalign;
  logic        timeout;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign off     = i_mem_addr[1:0];
  assign timeout = TO_EN && (cnt_q == TO_LAST);
  assign shifted = bus.rdata >> {addr_q[1:0], 3'b000};

  // Load wins when both ren and wen are set, so only its alignment matters then
  always_comb begin
    misalign = 1'b0;
    if (i_mem_ren) begin
      case (i_mem_read_t[1:0])
        2'b01:   misalign = (off == 2'b11);
        2'b10:   misalign = (off != 2'b00);
        default: misalign = 1'b0;
      endcase
    end else if (i_mem_wen) begin
      case (i_mem_wmask)
        4'b0011: misalign = (off == 2'b11);
        4'b1111: misalign = (off != 2'b00);
        default: misalign = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (read_t_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    read_t_d  = read_t_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    result_d  = result_q;
    err_d     = err_q;
    rd_d      = rd_q;
    reg_wen_d = reg_wen_q;
    pc_d      = pc_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          addr_d    = i_mem_addr;
          read_t_d  = i_mem_read_t;
          wdata_d   = i_mem_wdata << {off, 3'b000};
          wstrb_d   = i_mem_wmask << off;
          rd_d      = i_reg_rd;
          reg_wen_d = i_reg_wen;
          pc_d      = i_pc;
          result_d  = 32'd0;
          err_d     = 1'b0;
          cnt_d     = '0;
          if (misalign) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (i_mem_ren) begin
            state_d = S_AR;
          end else if (i_mem_wen) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_AWW;
          end else begin
            result_d = i_result;
            state_d  = S_DONE;
          end
        end
      end
      S_AR: begin
        if (bus.arready) begin
          cnt_d   = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (bus.rvalid) begin
          result_d = load_val;
          err_d    = (bus.rresp != 2'b00);
          state_d  = S_DONE;
        end else if (timeout) begin
          result_d = 32'd0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_AWW: begin
        // AW and W complete independently; leave once both have been taken
        if (awvalid_q && bus.awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || bus.awready) && (!wvalid_q || bus.wready)) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          cnt_d     = '0;
          state_d   = S_B;
        end
      end
      S_B: begin
        if (bus.bvalid) begin
          result_d = 32'd0;
          err_d    = (bus.bresp != 2'b00);
          state_d  = S_DONE;
        end else if (timeout) begin
          result_d = 32'd0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= 32'd0;
      read_t_q  <= 3'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      result_q  <= 32'd0;
      err_q     <= 1'b0;
      rd_q      <= 5'd0;
      reg_wen_q <= 1'b0;
      pc_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      read_t_q  <= read_t_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      result_q  <= result_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      reg_wen_q <= reg_wen_d;
      pc_q      <= pc_d;
    end
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_valid     = (state_q == S_DONE);
  assign o_result    = result_q;
  assign o_err       = err_q;
  assign o_reg_rd    = rd_q;
  assign o_reg_wen   = reg_wen_q && !err_q;
  assign o_pc        = pc_q;
  assign bus.araddr  = {addr_q[31:2], 2'b00};
  assign bus.arvalid = (state_q == S_AR);
  assign bus.rready  = (state_q == S_R);
  assign bus.awaddr  = {addr_q[31:2], 2'b00};
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = (state_q == S_B);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24110006_lsu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24110006_lsu : randomized bench with a bus slave and instruction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ysyx_24110006_lsu;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_valid, o_ready, ren, wen, rwen, o_valid, i_ready, o_reg_wen, o_err;
  logic [3:0]  wmask;
  logic [2:0]  rt;
  logic [31:0] addr, wdata, result, pc, o_result, o_pc;
  logic [4:0]  rd, o_reg_rd;

  ysyx_24110006_lsu_if bus();

  ysyx_24110006_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_ren(ren), .i_mem_wen(wen), .i_mem_wmask(wmask), .i_mem_read_t(rt),
    .i_mem_addr(addr), .i_mem_wdata(wdata), .i_result(result), .i_reg_rd(rd),
    .i_reg_wen(rwen), .i_pc(pc), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_reg_rd(o_reg_rd), .o_reg_wen(o_reg_wen), .o_pc(o_pc),
    .o_err(o_err), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus slave with its own memory ----------------
  logic [31:0] smem [16];
  logic [31:0] mmem [16];
  int  ar_dly, r_dly, aw_dly, w_dly, b_dly;
  bit  resp_err, drop;
  int  n_ar, n_aw, n_w, arw, rw, aww, ww, bw;
  bit  rd_pend, aw_done, w_done, wr_applied;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata, tmp_s;
  logic [3:0]  cap_wstrb;

  initial begin
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        rd_pend = 0; aw_done = 0; w_done = 0; wr_applied = 0;
        arw = 0; rw = 0; aww = 0; ww = 0; bw = 0;
      end else begin
        if (bus.arready) begin
          bus.arready = 0; rd_pend = 1; rw = 0;
        end else if (bus.arvalid) begin
          if (arw >= ar_dly) begin
            bus.arready = 1; cap_araddr = bus.araddr; n_ar++; arw = 0;
          end else arw++;
        end
        if (bus.rvalid) begin
          bus.rvalid = 0; rd_pend = 0;
        end else if (rd_pend && bus.rready && !drop) begin
          if (rw >= r_dly) begin
            bus.rvalid = 1;
            bus.rdata  = smem[cap_araddr[5:2]];
            bus.rresp  = resp_err ? 2'b10 : 2'b00;
          end else rw++;
        end
        if (bus.awready) begin
          bus.awready = 0; aw_done = 1;
        end else if (bus.awvalid) begin
          if (aww >= aw_dly) begin
            bus.awready = 1; cap_awaddr = bus.awaddr; n_aw++; aww = 0;
          end else aww++;
        end
        if (bus.wready) begin
          bus.wready = 0; w_done = 1;
        end else if (bus.wvalid) begin
          if (ww >= w_dly) begin
            bus.wready = 1; cap_wdata = bus.wdata; cap_wstrb = bus.wstrb; n_w++; ww = 0;
          end else ww++;
        end
        if (aw_done && w_done && !wr_applied) begin
          tmp_s = smem[cap_awaddr[5:2]];
          for (int i = 0; i < 4; i++)
            if (cap_wstrb[i]) tmp_s[8*i +: 8] = cap_wdata[8*i +: 8];
          smem[cap_awaddr[5:2]] = tmp_s;
          wr_applied = 1;
        end
        if (bus.bvalid) begin
          bus.bvalid = 0; aw_done = 0; w_done = 0;
        end else if (aw_done && w_done && bus.bready && !drop) begin
          if (bw >= b_dly) begin
            bus.bvalid = 1;
            bus.bresp  = resp_err ? 2'b10 : 2'b00;
          end else bw++;
        end
      end
    end
  end

  // ---------------- expected outputs and per-cycle compare ----------------
  logic [31:0] e_result, e_pc;
  logic [4:0]  e_rd;
  logic        e_err, e_rwen;
  bit          e_chk_res, exp_pending = 0;

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      chk("valid_expected", 32'(exp_pending), 32'd1);
      if (exp_pending) begin
        if (e_chk_res) chk("result", o_result, e_result);
        chk("err", 32'(o_err), 32'(e_err));
        chk("reg_rd", 32'(o_reg_rd), 32'(e_rd));
        chk("reg_wen", 32'(o_reg_wen), 32'(e_rwen));
        chk("pc", o_pc, e_pc);
      end
    end
  end

  task automatic set_knobs(input int a, input int r, input int aw, input int w, input int b,
                           input bit er, input bit dr);
    ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b; resp_err = er; drop = dr;
    n_ar = 0; n_aw = 0; n_w = 0; arw = 0; rw = 0; aww = 0; ww = 0; bw = 0;
    rd_pend = 0; aw_done = 0; w_done = 0; wr_applied = 0;
  endtask

  logic [31:0] obs_result;
  logic        obs_err, obs_rwen;
  int          obs_to;

  // Issue one instruction (called at a negedge while idle) and retire it
  task automatic do_instr(input bit r, input bit w, input logic [3:0] m, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] res,
                          input logic [4:0] rdv, input bit rwv, input logic [31:0] pcv,
                          input int hold);
    logic [1:0]  off;
    bit          mis, st;
    logic [31:0] sh, v, tmp;
    int          cyc, first_resp;
    off = a[1:0];
    mis = 0;
    if (r)      mis = (t[1:0] == 2'b01 && off == 2'd3) || (t[1:0] == 2'b10 && off != 2'd0);
    else if (w) mis = (m == 4'b0011 && off == 2'd3) || (m == 4'b1111 && off != 2'd0);
    st = !r && w && !mis;
    e_chk_res = 1;
    if (mis) begin
      e_err = 1; e_result = 0;
    end else if (r) begin
      sh = mmem[a[5:2]] >> (8 * off);
      case (t)
        3'b000: begin v = sh & 32'hFF;   if (v >= 128)   v = v - 256;   end
        3'b001: begin v = sh & 32'hFFFF; if (v >= 32768) v = v - 65536; end
        3'b100: v = sh & 32'hFF;
        3'b101: v = sh & 32'hFFFF;
        default: v = sh;
      endcase
      e_result = v; e_err = resp_err || drop; e_chk_res = !drop;
    end else if (w) begin
      e_result = 0; e_err = resp_err || drop; e_chk_res = !drop;
      tmp = mmem[a[5:2]];
      for (int i = 0; i < 4; i++)
        if (m[i] && (i + off) < 4) tmp[8*(i+off) +: 8] = wd[8*i +: 8];
      mmem[a[5:2]] = tmp;
    end else begin
      e_result = res; e_err = 0;
    end
    e_rd = rdv; e_rwen = rwv && !e_err; e_pc = pcv;

    chk("ready_before_accept", 32'(o_ready), 32'd1);
    ren = r; wen = w; wmask = m; rt = t; addr = a; wdata = wd; result = res;
    rd = rdv; rwen = rwv; pc = pcv; i_valid = 1; exp_pending = 1;
    @(posedge clk);
    cyc = 0; first_resp = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        i_valid = 0; ren = $urandom; wen = $urandom; addr = $urandom; wdata = $urandom;
        result = $urandom; rd = 5'($urandom); pc = $urandom; rwen = $urandom;
      end
      if (first_resp < 0 && (bus.rready || bus.bready)) first_resp = cyc;
      if (o_valid) break;
      if (cyc >= 60) begin
        chk("valid_within_budget", 32'(o_valid), 32'd1);
        break;
      end
    end
    obs_result = o_result; obs_err = o_err; obs_rwen = o_reg_wen;
    obs_to = (first_resp >= 0) ? cyc - first_resp : -1;

    if (mis || (!r && !w)) chk("latency_direct", 32'(cyc), 32'd1);
    else if (drop)         chk("latency_timeout", 32'(obs_to), 32'(TIMEOUT));
    else if (ar_dly == 0 && r_dly == 0 && aw_dly == 0 && w_dly == 0 && b_dly == 0)
      chk("latency_zero_wait", 32'(cyc), 32'd3);
    chk("n_ar", 32'(n_ar), (r && !mis) ? 32'd1 : 32'd0);
    chk("n_aw", 32'(n_aw), st ? 32'd1 : 32'd0);
    chk("n_w",  32'(n_w),  st ? 32'd1 : 32'd0);
    if (r && !mis) chk("araddr", cap_araddr, {a[31:2], 2'b00});
    if (st) begin
      chk("awaddr", cap_awaddr, {a[31:2], 2'b00});
      chk("wstrb", 32'(cap_wstrb), 32'(4'(m << off)));
      chk("wdata", cap_wdata, wd << (8 * off));
    end

    for (int h = 0; h < hold; h++) @(negedge clk);
    i_ready = 1;
    @(posedge clk);
    @(negedge clk);
    i_ready = 0;
    chk("released", 32'(o_valid), 32'd0);
    exp_pending = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    i_valid = 0; i_ready = 0; ren = 0; wen = 0; wmask = 0; rt = 0; addr = 0;
    wdata = 0; result = 0; rd = 0; rwen = 0; pc = 0;
    set_knobs(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      smem[i] = $urandom; mmem[i] = smem[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_ready",   32'(o_ready), 32'd1);
    chk("rst_valid",   32'(o_valid), 32'd0);
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_awvalid", 32'(bus.awvalid), 32'd0);
    chk("rst_wvalid",  32'(bus.wvalid), 32'd0);
    chk("rst_rready",  32'(bus.rready), 32'd0);
    chk("rst_bready",  32'(bus.bready), 32'd0);
    chk("rst_err",     32'(o_err), 32'd0);
    rst = 0;
    @(negedge clk);

    // Non-memory pass-through, held 3 cycles
    set_knobs(0, 0, 0, 0, 0, 0, 0);
    do_instr(0, 0, 4'b0000, 3'b000, 32'h80000000, 0, 32'h1234, 5'd5, 1, 32'h80000010, 3);
    chk("lit_passthru", obs_result, 32'h00001234);

    // LB / LBU at byte 3 of 0x80FF0000
    smem[0] = 32'h80FF0000; mmem[0] = 32'h80FF0000;
    set_knobs(0, 0, 0, 0, 0, 0, 0);
    do_instr(1, 0, 4'b0000, 3'b000, 32'h80000003, 0, 0, 5'd7, 1, 32'h80000014, 0);
    chk("lit_lb", obs_result, 32'hFFFFFF80);
    chk("lit_lb_araddr", cap_araddr, 32'h80000000);
    set_knobs(0, 0, 0, 0, 0, 0, 0);
    do_instr(1, 0, 4'b0000, 3'b100, 32'h80000003, 0, 0, 5'd7, 1, 32'h80000018, 1);
    chk("lit_lbu", obs_result, 32'h00000080);

    // SH with awready two cycles ahead of wready
    set_knobs(0, 0, 0, 2, 0, 0, 0);
    do_instr(0, 1, 4'b0011, 3'b000, 32'h80000002, 32'h0000ABCD, 0, 5'd0, 0, 32'h8000001C, 0);
    chk("lit_sh_wstrb", 32'(cap_wstrb), 32'h0000000C);
    chk("lit_sh_wdata", cap_wdata, 32'hABCD0000);

    // Misaligned LW
    set_knobs(0, 0, 0, 0, 0, 0, 0);
    do_instr(1, 0, 4'b0000, 3'b010, 32'h80000001, 0, 0, 5'd3, 1, 32'h80000020, 0);
    chk("lit_mis_err", 32'(obs_err), 32'd1);
    chk("lit_mis_rwen", 32'(obs_rwen), 32'd0);

    // Error response, then timeout
    set_knobs(1, 1, 0, 0, 0, 1, 0);
    do_instr(1, 0, 4'b0000, 3'b010, 32'h80000004, 0, 0, 5'd4, 1, 32'h80000024, 0);
    chk("lit_rresp_err", 32'(obs_err), 32'd1);
    set_knobs(0, 0, 0, 0, 0, 0, 1);
    do_instr(1, 0, 4'b0000, 3'b010, 32'h80000008, 0, 0, 5'd4, 1, 32'h80000028, 0);
    chk("lit_timeout_cycles", 32'(obs_to), 32'd4);
    chk("lit_timeout_err", 32'(obs_err), 32'd1);

    // Reset while waiting in AWW
    set_knobs(0, 0, 20, 20, 0, 0, 0);
    ren = 0; wen = 1; wmask = 4'b1111; addr = 32'h80000008; wdata = 32'h11223344; i_valid = 1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 0;
    chk("aww_awvalid", 32'(bus.awvalid), 32'd1);
    chk("aww_wvalid", 32'(bus.wvalid), 32'd1);
    rst = 1;
    @(negedge clk);
    chk("rstmid_awvalid", 32'(bus.awvalid), 32'd0);
    chk("rstmid_wvalid", 32'(bus.wvalid), 32'd0);
    chk("rstmid_ready", 32'(o_ready), 32'd1);
    chk("rstmid_valid", 32'(o_valid), 32'd0);
    rst = 0;
    @(negedge clk);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      int op;
      bit r, w;
      logic [3:0] m;
      logic [2:0] t;
      op = $urandom_range(0, 9);
      r = (op < 4) || (op == 9);
      w = (op >= 4 && op < 8) || (op == 9);
      case ($urandom_range(0, 2))
        0: m = 4'b0001;
        1: m = 4'b0011;
        default: m = 4'b1111;
      endcase
      case ($urandom_range(0, 4))
        0: t = 3'b000;
        1: t = 3'b001;
        2: t = 3'b010;
        3: t = 3'b100;
        default: t = 3'b101;
      endcase
      set_knobs($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      do_instr(r, w, m, t, 32'h80000000 | 32'($urandom_range(0, 63)), $urandom, $urandom,
               5'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
